pp_reduction_sequencer: RTL and testbench



---
 rtl/pp_reduction_sequencer.sv | 201 ++++++++++++++++++++
 tb/tb_pp_reduction_sequencer.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pp_reduction_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : compressor_42 / pp_reduction_sequencer
// Brief    : Sequential Booth partial-product reducer. Two partial products
//            per beat are folded into running sum/carry registers through a
//            single 4:2 compressor; a registered carry-propagate add then
//            produces the final WIDTH-bit result.
// Revision : 1.0 - initial release
// ============================================================================

// 4:2 compressor built from two full-adder rows. The carry output is already
// shifted left by one so that a+b+c+d == sum+carry (mod 2^WIDTH).
module compressor_42 #(
    parameter int WIDTH = 128
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] sum,
    output logic [WIDTH-1:0] carry
);

    logic [WIDTH-1:0] w_s1;
    logic [WIDTH-1:0] w_cin;
    logic [WIDTH-2:0] w_c1;

    assign carry[0] = 1'b0;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign w_s1[i] = a[i] ^ b[i] ^ c[i];
        if (i == 0) begin : g_lsb
            assign w_cin[i] = 1'b0;
        end else begin : g_chain
            assign w_cin[i] = w_c1[i-1];
        end
        assign sum[i] = w_s1[i] ^ d[i] ^ w_cin[i];
        // Carries out of the top bit fall outside the modulus and are dropped.
        if (i < WIDTH - 1) begin : g_carry
            assign w_c1[i]    = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
            assign carry[i+1] = (w_s1[i] & d[i]) | (w_s1[i] & w_cin[i]) | (d[i] & w_cin[i]);
        end
    end

endmodule

module pp_reduction_sequencer #(
    parameter int WIDTH  = 128,
    parameter int MAX_PP = 16,
    parameter int CNT_W  = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] pp_count,
    output logic             busy,
    output logic             err,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_pp0,
    input  logic [WIDTH-1:0] in_pp1,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result
);

    localparam logic [CNT_W-1:0] c_MAX_PP = CNT_W'(MAX_PP);
    localparam logic [CNT_W-1:0] c_ONE    = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_FINAL = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic [WIDTH-1:0] r_sum;
    logic [WIDTH-1:0] r_carry;
    logic [WIDTH-1:0] r_result;
    logic [CNT_W-1:0] r_beats_left;
    logic             r_odd;
    logic             r_err;

    logic             w_count_ok;
    logic [CNT_W-1:0] w_beats_init;
    logic             w_beat_fire;
    logic             w_last_beat;
    logic [WIDTH-1:0] w_lane1;
    logic [WIDTH-1:0] w_cmp_sum;
    logic [WIDTH-1:0] w_cmp_carry;

    assign w_count_ok   = (pp_count != '0) && (pp_count <= c_MAX_PP);
    // ceil(pp_count/2) without needing an extra carry bit
    assign w_beats_init = (pp_count >> 1) + {{(CNT_W-1){1'b0}}, pp_count[0]};
    assign w_beat_fire  = in_valid && in_ready;
    assign w_last_beat  = (r_beats_left == c_ONE);
    // The final beat of an odd count carries only one real partial product.
    assign w_lane1      = (w_last_beat && r_odd) ? '0 : in_pp1;

    compressor_42 #(
        .WIDTH (WIDTH)
    ) u_cmp (
        .a     (r_sum),
        .b     (r_carry),
        .c     (in_pp0),
        .d     (w_lane1),
        .sum   (w_cmp_sum),
        .carry (w_cmp_carry)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode and handshake outputs
    always_comb begin
        w_next_state = r_state;
        busy         = 1'b1;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start && w_count_ok) begin
                    w_next_state = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                in_ready = 1'b1;
                if (in_valid && w_last_beat) begin
                    w_next_state = ST_FINAL;
                end
            end
            ST_FINAL: begin
                w_next_state = ST_DONE;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Datapath: operation setup, beat accumulation and final carry-propagate add
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sum        <= '0;
            r_carry      <= '0;
            r_result     <= '0;
            r_beats_left <= '0;
            r_odd        <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        if (w_count_ok) begin
                            r_beats_left <= w_beats_init;
                            r_odd        <= pp_count[0];
                            r_sum        <= '0;
                            r_carry      <= '0;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                ST_ACCUM: begin
                    if (w_beat_fire) begin
                        r_sum        <= w_cmp_sum;
                        r_carry      <= w_cmp_carry;
                        r_beats_left <= r_beats_left - c_ONE;
                    end
                end
                ST_FINAL: begin
                    r_result <= r_sum + r_carry;
                end
                default: begin
                end
            endcase
        end
    end

    assign err        = r_err;
    assign out_result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_pp_reduction_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pp_reduction_sequencer
// Brief    : Self-checking bench for pp_reduction_sequencer with a queue of
//            expected results filled at stimulus time.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pp_reduction_sequencer;

    localparam int WIDTH = 128;
    localparam int CNT_W = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [CNT_W-1:0] pp_count;
    logic             busy;
    logic             err;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_pp0;
    logic [WIDTH-1:0] in_pp1;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;

    int vectors     = 0;
    int miscompares = 0;

    logic [WIDTH-1:0] pp_mem [0:17];
    logic [WIDTH-1:0] exp_q [$];

    pp_reduction_sequencer #(
        .WIDTH  (WIDTH),
        .MAX_PP (16),
        .CNT_W  (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .pp_count   (pp_count),
        .busy       (busy),
        .err        (err),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_pp0     (in_pp0),
        .in_pp1     (in_pp1),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result)
    );

    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // One full operation: start, feed beats, optional DONE stall, handshake.
    task automatic run_op(input int n, input int gap, input int hold, input bit poke_start,
                          input string name);
        int               beats;
        int               b;
        int               cyc;
        int               lat;
        bit               acc;
        bit               got;
        logic [WIDTH-1:0] exp;
        beats = (n + 1) / 2;
        exp   = '0;
        for (int i = 0; i < n; i++) exp = exp + pp_mem[i];
        exp_q.push_back(exp);

        @(negedge clk);
        start    = 1'b1;
        pp_count = CNT_W'(n);
        in_valid = 1'b1;
        in_pp0   = pp_mem[0];
        in_pp1   = pp_mem[1];
        @(negedge clk);
        start = 1'b0;
        lat   = 1;
        vectors++;
        if (busy !== 1'b1 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL %s accum_entry busy=%b in_ready=%b required 1/1", name, busy, in_ready);
        end

        b   = 0;
        cyc = 0;
        while (b < beats && cyc < 200) begin
            in_valid = (gap == 0) || (cyc % 2 == 1);
            if (in_valid) begin
                in_pp0 = pp_mem[2*b];
                in_pp1 = pp_mem[2*b+1];
            end else begin
                in_pp0 = rand128();
                in_pp1 = rand128();
            end
            acc = in_valid && in_ready;
            @(negedge clk);
            lat++;
            cyc++;
            if (acc) b++;
        end
        in_valid = 1'b0;
        vectors++;
        if (b < beats) begin
            miscompares++;
            $display("FAIL %s beat_timeout accepted=%0d required %0d", name, b, beats);
        end

        vectors++;
        if (in_ready !== 1'b0 || busy !== 1'b1 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL %s final_state in_ready=%b busy=%b out_valid=%b required 0/1/0",
                     name, in_ready, busy, out_valid);
        end

        got = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (out_valid === 1'b1) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
            lat++;
        end
        vectors++;
        if (!got) begin
            miscompares++;
            $display("FAIL %s out_valid_timeout got=0 required 1", name);
        end
        if (gap == 0) begin
            vectors++;
            if (lat != beats + 2) begin
                miscompares++;
                $display("FAIL %s latency got=%0d required %0d", name, lat, beats + 2);
            end
        end

        out_ready = 1'b0;
        for (int h = 0; h < hold; h++) begin
            if (poke_start) begin
                start    = 1'b1;
                pp_count = CNT_W'(2);
            end
            @(negedge clk);
            vectors++;
            if (out_valid !== 1'b1 || out_result !== exp_q[0]) begin
                miscompares++;
                $display("FAIL %s stall_hold out_valid=%b result=%h required 1 %h",
                         name, out_valid, out_result, exp_q[0]);
            end
        end
        start = 1'b0;

        out_ready = 1'b1;
        exp = exp_q.pop_front();
        vectors++;
        if (out_result !== exp) begin
            miscompares++;
            $display("FAIL %s result got=%h required %h", name, out_result, exp);
        end
        @(negedge clk);
        out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if (out_valid !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin
                miscompares++;
                $display("FAIL %s post_handshake out_valid=%b busy=%b err=%b required 0/0/0",
                         name, out_valid, busy, err);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        start     = 1'b0;
        pp_count  = '0;
        in_valid  = 1'b0;
        in_pp0    = '0;
        in_pp1    = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || err !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl busy=%b err=%b in_ready=%b out_valid=%b required 0/0/0/0",
                     busy, err, in_ready, out_valid);
        end
        vectors++;
        if (out_result !== '0) begin
            miscompares++;
            $display("FAIL reset_result got=%h required 0", out_result);
        end
    endtask

    task automatic test_even4();
        for (int i = 0; i < 18; i++) pp_mem[i] = rand128();
        pp_mem[0] = 128'd1; pp_mem[1] = 128'd2; pp_mem[2] = 128'd3; pp_mem[3] = 128'd4;
        run_op(4, 0, 0, 1'b0, "even4");
    endtask

    task automatic test_odd3();
        pp_mem[0] = 128'd5; pp_mem[1] = 128'd7; pp_mem[2] = 128'd9;
        pp_mem[3] = '1;
        run_op(3, 0, 0, 1'b0, "odd3");
    endtask

    task automatic test_wrap();
        pp_mem[0] = '1; pp_mem[1] = '1;
        run_op(2, 0, 0, 1'b0, "wrap");
    endtask

    task automatic test_count16_stall();
        for (int i = 0; i < 18; i++) pp_mem[i] = rand128();
        run_op(16, 1, 5, 1'b1, "count16");
    endtask

    task automatic test_err();
        int bad [2];
        bad[0] = 0;
        bad[1] = 17;
        foreach (bad[j]) begin
            @(negedge clk);
            start    = 1'b1;
            pp_count = CNT_W'(bad[j]);
            @(negedge clk);
            start = 1'b0;
            vectors++;
            if (err !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL err_pulse count=%0d err=%b busy=%b in_ready=%b required 1/0/0",
                         bad[j], err, busy, in_ready);
            end
            @(negedge clk);
            vectors++;
            if (err !== 1'b0 || busy !== 1'b0) begin
                miscompares++;
                $display("FAIL err_clear count=%0d err=%b busy=%b required 0/0", bad[j], err, busy);
            end
        end
    endtask

    task automatic test_rst_mid();
        @(negedge clk);
        start    = 1'b1;
        pp_count = CNT_W'(4);
        in_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1;
            in_pp0   = rand128();
            in_pp1   = rand128();
            @(negedge clk);
        end
        in_valid = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        vectors++;
        if (busy !== 1'b0 || err !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0
            || out_result !== '0) begin
            miscompares++;
            $display("FAIL rst_mid busy=%b err=%b in_ready=%b out_valid=%b result=%h required all 0",
                     busy, err, in_ready, out_valid, out_result);
        end
        repeat (2) @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_mid_quiet out_valid=%b busy=%b required 0/0", out_valid, busy);
        end
        pp_mem[0] = 128'd3; pp_mem[1] = 128'd4;
        run_op(2, 0, 0, 1'b0, "after_rst");
    endtask

    initial begin
        test_reset();
        test_even4();
        test_odd3();
        test_wrap();
        test_count16_stall();
        test_err();
        test_rst_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
